// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage. Issues in-order word requests to instruction memory,
// buffers responses in a small FIFO, and presents the head to decode as an
// instr/pc pair. The head is held while decode stalls. A branch redirect from
// execute flushes the buffer and drops any responses still in flight.
//
// Ports
//   clk               in   1   clock, rising edge
//   reset             in   1   asynchronous, active-low reset
//   imem_req_valid    out  1   fetch request valid
//   imem_req_ready    in   1   memory accepts the request this cycle
//   imem_req_addr     out  32  word-aligned fetch address
//   imem_rsp_valid    in   1   response valid (in order, >=1 cycle after accept)
//   imem_rsp_data     in   32  fetched instruction
//   stall_in          in   1   decode cannot take the head this cycle
//   branch_taken_in   in   1   redirect request from execute
//   branch_target_in  in   32  redirect address (bits [1:0] ignored)
//   valid_out         out  1   instr_out/pc_out hold a valid instruction
//   instr_out         out  32  instruction at the buffer head (NOP when empty)
//   pc_out            out  32  address of instr_out (last handed-off pc when empty)
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        stall_in,
   input  logic        branch_taken_in,
   input  logic [31:0] branch_target_in,
   output logic        valid_out,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out
);

   localparam int          AW         = $clog2(FIFO_DEPTH);
   localparam int          CW         = AW + 1;
   localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(FIFO_DEPTH);

   logic [31:0]   fetch_pc_reg;
   logic [31:0]   last_pc_reg;
   logic [CW-1:0] fifo_count_reg;
   logic [CW-1:0] outstanding_reg;
   logic [CW-1:0] discard_reg;
   logic [AW-1:0] fifo_wr_reg;
   logic [AW-1:0] fifo_rd_reg;
   logic [AW-1:0] addr_wr_reg;
   logic [AW-1:0] addr_rd_reg;

   // Instruction buffer and the queue of addresses whose data is still in flight.
   logic [31:0]   instr_buf [FIFO_DEPTH];
   logic [31:0]   pc_buf    [FIFO_DEPTH];
   logic [31:0]   addr_buf  [FIFO_DEPTH];

   logic [CW:0]   credit_used;
   logic          req_fire;
   logic          rsp_keep;
   logic          rsp_drop;
   logic          push;
   logic          pop;
   logic          unused_target_bits;

   assign unused_target_bits = ^branch_target_in[1:0];

   // A request is only issued if its response is guaranteed a buffer slot:
   // buffered entries plus requests in flight never exceed the buffer depth.
   assign credit_used    = {1'b0, fifo_count_reg} + {1'b0, outstanding_reg};
   assign imem_req_valid = reset && !branch_taken_in && (credit_used < CREDIT_MAX);
   assign imem_req_addr  = fetch_pc_reg;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // Responses belonging to requests issued before a redirect are dropped.
   assign rsp_keep = imem_rsp_valid && (discard_reg == '0);
   assign rsp_drop = imem_rsp_valid && (discard_reg != '0);
   assign push     = rsp_keep && !branch_taken_in;

   assign valid_out = (fifo_count_reg != '0);
   assign pop       = valid_out && !stall_in;
   assign instr_out = valid_out ? instr_buf[fifo_rd_reg] : NOP_INSTR;
   assign pc_out    = valid_out ? pc_buf[fifo_rd_reg]    : last_pc_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_reg    <= RESET_PC;
         last_pc_reg     <= RESET_PC;
         fifo_count_reg  <= '0;
         outstanding_reg <= '0;
         discard_reg     <= '0;
         fifo_wr_reg     <= '0;
         fifo_rd_reg     <= '0;
         addr_wr_reg     <= '0;
         addr_rd_reg     <= '0;
      end else begin
         // Every response retires one in-flight request, kept or dropped.
         outstanding_reg <= outstanding_reg + CW'(req_fire) - CW'(imem_rsp_valid);
         if (pop) begin
            last_pc_reg <= pc_out;
         end
         if (branch_taken_in) begin
            fetch_pc_reg   <= {branch_target_in[31:2], 2'b00};
            fifo_count_reg <= '0;
            fifo_wr_reg    <= '0;
            fifo_rd_reg    <= '0;
            addr_wr_reg    <= '0;
            addr_rd_reg    <= '0;
            // Everything still in flight after this edge is stale. The
            // outstanding count already includes earlier stale requests, so
            // back-to-back redirects need no accumulation of their own.
            discard_reg    <= outstanding_reg - CW'(imem_rsp_valid);
         end else begin
            if (req_fire) begin
               fetch_pc_reg <= fetch_pc_reg + 32'd4;
               addr_wr_reg  <= addr_wr_reg + AW'(1);
            end
            if (rsp_keep) begin
               addr_rd_reg <= addr_rd_reg + AW'(1);
            end
            if (rsp_drop) begin
               discard_reg <= discard_reg - CW'(1);
            end
            if (push) begin
               fifo_wr_reg <= fifo_wr_reg + AW'(1);
            end
            if (pop) begin
               fifo_rd_reg <= fifo_rd_reg + AW'(1);
            end
            fifo_count_reg <= fifo_count_reg + CW'(push) - CW'(pop);
         end
      end
   end

   // Storage needs no reset: occupancy is tracked by the counters above.
   always_ff @(posedge clk) begin
      if (req_fire) begin
         addr_buf[addr_wr_reg] <= fetch_pc_reg;
      end
      if (push) begin
         instr_buf[fifo_wr_reg] <= imem_rsp_data;
         pc_buf[fifo_wr_reg]    <= addr_buf[addr_rd_reg];
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        stall_in = 1'b0;
   logic        branch_taken_in = 1'b0;
   logic [31:0] branch_target_in = 32'h0;
   logic        valid_out;
   logic [31:0] instr_out;
   logic [31:0] pc_out;

   int          checks = 0;
   int          failures = 0;
   int          consumed = 0;
   logic [31:0] exp_req = RESET_PC;
   logic [31:0] exp_pc = RESET_PC;
   logic        rsp_hold = 1'b0;
   logic [31:0] pending [$];

   always #5 clk = ~clk;

   fetch_stage #(
      .RESET_PC   (RESET_PC),
      .FIFO_DEPTH (2),
      .NOP_INSTR  (NOP_INSTR)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .imem_req_valid   (imem_req_valid),
      .imem_req_ready   (imem_req_ready),
      .imem_req_addr    (imem_req_addr),
      .imem_rsp_valid   (imem_rsp_valid),
      .imem_rsp_data    (imem_rsp_data),
      .stall_in         (stall_in),
      .branch_taken_in  (branch_taken_in),
      .branch_target_in (branch_target_in),
      .valid_out        (valid_out),
      .instr_out        (instr_out),
      .pc_out           (pc_out)
   );

   // Memory contents: every word holds a value derived from its address.
   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a + 32'h1000_0003;
   endfunction

   // One clock cycle, with the memory model: a request accepted at an edge is
   // answered during the following cycle (1-cycle latency) unless rsp_hold.
   task automatic step();
      logic        fire;
      logic [31:0] a;
      #1;
      fire = reset && imem_req_valid && imem_req_ready;
      a    = imem_req_addr;
      @(posedge clk);
      #1;
      if (!reset) begin
         pending.delete();
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end else begin
         if (fire) pending.push_back(a);
         if (!rsp_hold && pending.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(pending[0]);
            void'(pending.pop_front());
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) step();
      #1;
      checks++;
      if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
      checks++;
      if (instr_out !== NOP_INSTR) begin failures++; $display("FAIL reset_instr got=%h exp=%h", instr_out, NOP_INSTR); end
      checks++;
      if (pc_out !== RESET_PC) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc_out, RESET_PC); end
      checks++;
      if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
      checks++;
      if (imem_req_addr !== RESET_PC) begin failures++; $display("FAIL reset_req_addr got=%h exp=%h", imem_req_addr, RESET_PC); end
      reset   = 1'b1;
      exp_req = RESET_PC;
      exp_pc  = RESET_PC;
   endtask

   task automatic test_stream();
      consumed = 0;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (imem_req_valid) begin
            checks++;
            if (imem_req_addr !== exp_req) begin failures++; $display("FAIL stream_req_addr got=%h exp=%h", imem_req_addr, exp_req); end
            if (imem_req_ready) exp_req = exp_req + 32'd4;
         end
         if (valid_out && !stall_in) begin
            checks++;
            if (pc_out !== exp_pc || instr_out !== instr_of(exp_pc)) begin
               failures++; $display("FAIL stream_out got=%h/%h exp=%h/%h", pc_out, instr_out, exp_pc, instr_of(exp_pc));
            end
            $display("consume pc=%h instr=%h", pc_out, instr_out);
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         step();
      end
      checks++;
      if (consumed < 6) begin failures++; $display("FAIL stream_count got=%0d exp>=6", consumed); end
   endtask

   task automatic test_stall();
      stall_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (imem_req_valid) begin
            checks++;
            if (imem_req_addr !== exp_req) begin failures++; $display("FAIL stall_req_addr got=%h exp=%h", imem_req_addr, exp_req); end
            if (imem_req_ready) exp_req = exp_req + 32'd4;
         end
         if (i >= 3) begin
            checks++;
            if (valid_out !== 1'b1 || pc_out !== exp_pc || instr_out !== instr_of(exp_pc)) begin
               failures++; $display("FAIL stall_head got=%b %h/%h exp=1 %h/%h", valid_out, pc_out, instr_out, exp_pc, instr_of(exp_pc));
            end
         end
         step();
      end
      #1;
      checks++;
      if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_credit got=%b exp=0", imem_req_valid); end
      stall_in = 1'b0;
      consumed = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (imem_req_valid) begin
            checks++;
            if (imem_req_addr !== exp_req) begin failures++; $display("FAIL stall_rel_req got=%h exp=%h", imem_req_addr, exp_req); end
            if (imem_req_ready) exp_req = exp_req + 32'd4;
         end
         if (valid_out && !stall_in) begin
            checks++;
            if (pc_out !== exp_pc || instr_out !== instr_of(exp_pc)) begin
               failures++; $display("FAIL stall_rel_out got=%h/%h exp=%h/%h", pc_out, instr_out, exp_pc, instr_of(exp_pc));
            end
            $display("consume pc=%h instr=%h", pc_out, instr_out);
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         step();
      end
      checks++;
      if (consumed < 4) begin failures++; $display("FAIL stall_rel_count got=%0d exp>=4", consumed); end
   endtask

   task automatic test_branch_flush();
      rsp_hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (imem_req_valid) begin
            checks++;
            if (imem_req_addr !== exp_req) begin failures++; $display("FAIL flush_req_addr got=%h exp=%h", imem_req_addr, exp_req); end
            if (imem_req_ready) exp_req = exp_req + 32'd4;
         end
         if (valid_out && !stall_in) begin
            checks++;
            if (pc_out !== exp_pc) begin failures++; $display("FAIL flush_drain got=%h exp=%h", pc_out, exp_pc); end
            exp_pc = exp_pc + 32'd4;
         end
         step();
      end
      #1;
      checks++;
      if (imem_req_valid !== 1'b0 || valid_out !== 1'b0) begin
         failures++; $display("FAIL flush_inflight got=%b/%b exp=0/0", imem_req_valid, valid_out);
      end
      rsp_hold = 1'b0;
      step();
      branch_taken_in  = 1'b1;
      branch_target_in = 32'h0000_0100;
      #1;
      checks++;
      if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL flush_req_in_redirect got=%b exp=0", imem_req_valid); end
      step();
      branch_taken_in = 1'b0;
      #1;
      checks++;
      if (valid_out !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", valid_out); end
      exp_req  = 32'h0000_0100;
      exp_pc   = 32'h0000_0100;
      consumed = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (imem_req_valid) begin
            checks++;
            if (imem_req_addr !== exp_req) begin failures++; $display("FAIL flush_new_req got=%h exp=%h", imem_req_addr, exp_req); end
            if (imem_req_ready) exp_req = exp_req + 32'd4;
         end
         if (valid_out && !stall_in) begin
            checks++;
            if (pc_out !== exp_pc || instr_out !== instr_of(exp_pc)) begin
               failures++; $display("FAIL flush_new_out got=%h/%h exp=%h/%h", pc_out, instr_out, exp_pc, instr_of(exp_pc));
            end
            $display("consume pc=%h instr=%h", pc_out, instr_out);
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         step();
      end
      checks++;
      if (consumed < 3) begin failures++; $display("FAIL flush_new_count got=%0d exp>=3", consumed); end
   endtask

   task automatic test_ready_low();
      imem_req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (imem_req_valid) begin
            checks++;
            if (imem_req_addr !== exp_req) begin failures++; $display("FAIL rdy_warm_req got=%h exp=%h", imem_req_addr, exp_req); end
         end
         if (valid_out && !stall_in) begin
            checks++;
            if (pc_out !== exp_pc) begin failures++; $display("FAIL rdy_drain got=%h exp=%h", pc_out, exp_pc); end
            exp_pc = exp_pc + 32'd4;
         end
         step();
      end
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_req) begin
            failures++; $display("FAIL rdy_hold got=%b/%h exp=1/%h", imem_req_valid, imem_req_addr, exp_req);
         end
         step();
      end
      imem_req_ready = 1'b1;
      consumed = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (imem_req_valid) begin
            checks++;
            if (imem_req_addr !== exp_req) begin failures++; $display("FAIL rdy_resume_req got=%h exp=%h", imem_req_addr, exp_req); end
            if (imem_req_ready) exp_req = exp_req + 32'd4;
         end
         if (valid_out && !stall_in) begin
            checks++;
            if (pc_out !== exp_pc || instr_out !== instr_of(exp_pc)) begin
               failures++; $display("FAIL rdy_resume_out got=%h/%h exp=%h/%h", pc_out, instr_out, exp_pc, instr_of(exp_pc));
            end
            $display("consume pc=%h instr=%h", pc_out, instr_out);
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         step();
      end
      checks++;
      if (consumed < 3) begin failures++; $display("FAIL rdy_resume_count got=%0d exp>=3", consumed); end
   endtask

   task automatic test_align_wrap();
      // Fill the buffer under stall, then redirect while still stalled.
      stall_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (imem_req_valid) begin
            checks++;
            if (imem_req_addr !== exp_req) begin failures++; $display("FAIL align_pre_req got=%h exp=%h", imem_req_addr, exp_req); end
            if (imem_req_ready) exp_req = exp_req + 32'd4;
         end
         step();
      end
      #1;
      checks++;
      if (valid_out !== 1'b1) begin failures++; $display("FAIL align_pre_valid got=%b exp=1", valid_out); end
      branch_taken_in  = 1'b1;
      branch_target_in = 32'h0000_0102;
      step();
      branch_taken_in = 1'b0;
      stall_in        = 1'b0;
      #1;
      checks++;
      if (valid_out !== 1'b0) begin failures++; $display("FAIL align_flush_valid got=%b exp=0", valid_out); end
      checks++;
      if (imem_req_addr !== 32'h0000_0100) begin failures++; $display("FAIL align_addr got=%h exp=00000100", imem_req_addr); end
      exp_req = 32'h0000_0100;
      exp_pc  = 32'h0000_0100;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (imem_req_valid) begin
            checks++;
            if (imem_req_addr !== exp_req) begin failures++; $display("FAIL align_req got=%h exp=%h", imem_req_addr, exp_req); end
            if (imem_req_ready) exp_req = exp_req + 32'd4;
         end
         if (valid_out && !stall_in) begin
            checks++;
            if (pc_out !== exp_pc) begin failures++; $display("FAIL align_out got=%h exp=%h", pc_out, exp_pc); end
            $display("consume pc=%h instr=%h", pc_out, instr_out);
            exp_pc = exp_pc + 32'd4;
         end
         step();
      end
      branch_taken_in  = 1'b1;
      branch_target_in = 32'hFFFF_FFFC;
      step();
      branch_taken_in = 1'b0;
      #1;
      checks++;
      if (imem_req_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr got=%h exp=fffffffc", imem_req_addr); end
      exp_req  = 32'hFFFF_FFFC;
      exp_pc   = 32'hFFFF_FFFC;
      consumed = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (imem_req_valid) begin
            checks++;
            if (imem_req_addr !== exp_req) begin failures++; $display("FAIL wrap_req got=%h exp=%h", imem_req_addr, exp_req); end
            if (imem_req_ready) exp_req = exp_req + 32'd4;
         end
         if (valid_out && !stall_in) begin
            checks++;
            if (pc_out !== exp_pc || instr_out !== instr_of(exp_pc)) begin
               failures++; $display("FAIL wrap_out got=%h/%h exp=%h/%h", pc_out, instr_out, exp_pc, instr_of(exp_pc));
            end
            $display("consume pc=%h instr=%h", pc_out, instr_out);
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         step();
      end
      checks++;
      if (consumed < 3) begin failures++; $display("FAIL wrap_count got=%0d exp>=3", consumed); end
   endtask

   task automatic test_back_to_back();
      rsp_hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (imem_req_valid) begin
            checks++;
            if (imem_req_addr !== exp_req) begin failures++; $display("FAIL b2b_req got=%h exp=%h", imem_req_addr, exp_req); end
            if (imem_req_ready) exp_req = exp_req + 32'd4;
         end
         if (valid_out && !stall_in) begin
            checks++;
            if (pc_out !== exp_pc) begin failures++; $display("FAIL b2b_drain got=%h exp=%h", pc_out, exp_pc); end
            exp_pc = exp_pc + 32'd4;
         end
         step();
      end
      #1;
      checks++;
      if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL b2b_inflight got=%b exp=0", imem_req_valid); end
      branch_taken_in  = 1'b1;
      branch_target_in = 32'h0000_0200;
      stall_in         = 1'b1;
      step();
      branch_target_in = 32'h0000_0300;
      stall_in         = 1'b0;
      step();
      branch_taken_in = 1'b0;
      rsp_hold        = 1'b0;
      #1;
      checks++;
      if (valid_out !== 1'b0 || imem_req_addr !== 32'h0000_0300) begin
         failures++; $display("FAIL b2b_target got=%b/%h exp=0/00000300", valid_out, imem_req_addr);
      end
      exp_req  = 32'h0000_0300;
      exp_pc   = 32'h0000_0300;
      consumed = 0;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (imem_req_valid) begin
            checks++;
            if (imem_req_addr !== exp_req) begin failures++; $display("FAIL b2b_new_req got=%h exp=%h", imem_req_addr, exp_req); end
            if (imem_req_ready) exp_req = exp_req + 32'd4;
         end
         if (valid_out && !stall_in) begin
            checks++;
            if (pc_out !== exp_pc || instr_out !== instr_of(exp_pc)) begin
               failures++; $display("FAIL b2b_new_out got=%h/%h exp=%h/%h", pc_out, instr_out, exp_pc, instr_of(exp_pc));
            end
            $display("consume pc=%h instr=%h", pc_out, instr_out);
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         step();
      end
      checks++;
      if (consumed < 3) begin failures++; $display("FAIL b2b_new_count got=%0d exp>=3", consumed); end
   endtask

   task automatic test_reset_mid();
      rsp_hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (imem_req_valid) begin
            if (imem_req_ready) exp_req = exp_req + 32'd4;
         end
         if (valid_out && !stall_in) begin
            checks++;
            if (pc_out !== exp_pc) begin failures++; $display("FAIL rst_mid_drain got=%h exp=%h", pc_out, exp_pc); end
            exp_pc = exp_pc + 32'd4;
         end
         step();
      end
      #1;
      checks++;
      if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_inflight got=%b exp=0", imem_req_valid); end
      reset = 1'b0;
      #1;
      checks++;
      if (valid_out !== 1'b0 || instr_out !== NOP_INSTR) begin
         failures++; $display("FAIL rst_mid_out got=%b/%h exp=0/%h", valid_out, instr_out, NOP_INSTR);
      end
      checks++;
      if (pc_out !== RESET_PC || imem_req_addr !== RESET_PC || imem_req_valid !== 1'b0) begin
         failures++; $display("FAIL rst_mid_pc got=%h/%h/%b exp=%h/%h/0", pc_out, imem_req_addr, imem_req_valid, RESET_PC, RESET_PC);
      end
      rsp_hold = 1'b0;
      repeat (2) step();
      reset    = 1'b1;
      exp_req  = RESET_PC;
      exp_pc   = RESET_PC;
      consumed = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (imem_req_valid) begin
            checks++;
            if (imem_req_addr !== exp_req) begin failures++; $display("FAIL rst_mid_req got=%h exp=%h", imem_req_addr, exp_req); end
            if (imem_req_ready) exp_req = exp_req + 32'd4;
         end
         if (valid_out && !stall_in) begin
            checks++;
            if (pc_out !== exp_pc || instr_out !== instr_of(exp_pc)) begin
               failures++; $display("FAIL rst_mid_refetch got=%h/%h exp=%h/%h", pc_out, instr_out, exp_pc, instr_of(exp_pc));
            end
            $display("consume pc=%h instr=%h", pc_out, instr_out);
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         step();
      end
      checks++;
      if (consumed < 4) begin failures++; $display("FAIL rst_mid_count got=%0d exp>=4", consumed); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_branch_flush();
      test_ready_low();
      test_align_wrap();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
